seq_detect_moore: RTL and testbench
===================================

# seq_detect_moore

Parametrised Moore-style serial pattern detector, successor to the fixed 4-bit overlapping detector. It matches any `PAT_LEN`-bit pattern on a single-bit stream and qualifies input bits with a valid strobe. Overlap/non-overlap mode is selectable at run time, and a saturating match counter is included. It sits on the serial receive path and feeds frame-sync and statistics logic.

## Interface
Parameters:
- `PAT_LEN`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1011: `PAT_LEN`-bit pattern. `PATTERN[PAT_LEN-1]` is the first bit received.
- `CNT_W`, default 8: match counter width, ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial data bit.
- `din_vld`  in  1  `din` is consumed only on cycles where this is 1.
- `ovl`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `y`  out  1  Moore match flag.
- `match_cnt`  out  `CNT_W`  saturating count of matches.

## Operation
- State `st` holds the number of pattern bits currently matched, 0..`PAT_LEN`. Width is $clog2(`PAT_LEN`+1). State `PAT_LEN` is the MATCH state.
- On `din_vld`=0, `st` holds its value.
- On `din_vld`=1 with `st` < `PAT_LEN`:
  - Next state is the longest prefix of `PATTERN` that is a suffix of (matched bits, `din`).
  - This is the KMP transition, computed at elaboration; there is no run-time table.
- On `din_vld`=1 with `st` = `PAT_LEN`:
  - `ovl`=1: next state = transition from the failure state of the full pattern with `din` (longest proper border, then `din`).
  - `ovl`=0: restart. Next state = 1 if `din` = `PATTERN[PAT_LEN-1]`, else 0.
- `ovl` is examined only on a valid bit taken from MATCH. Changing it at any other time has no effect.
- `y` = (`st` == `PAT_LEN`). It is a pure function of state, with no `din` path.
- `match_cnt` increments by 1 on every clock edge where `st` enters MATCH. This includes MATCH→MATCH in overlap mode.
  - It saturates at 2^`CNT_W`−1 and does not wrap.
- `cnt_clr`=1 forces `match_cnt` to 0 on that edge.
  - Clear has priority over a simultaneous increment; result is 0.
  - `cnt_clr` does not affect `st` or `y`.
- Reset (`rst_n`=0, any time, including mid-pattern):
  - `st`=0, `y`=0, `match_cnt`=0 immediately.
  - Partial matches are discarded.

## Timing
- Detection latency: the valid bit completing the pattern is sampled at edge k, and `y`=1 from edge k onward.
- `y` stays 1 until the edge consuming the next valid bit. With `din_vld` gaps, `y` stretches across the idle cycles.
- `match_cnt` updates on the same edge that `y` rises, with no extra latency.
- Back-to-back matches in overlap mode produce `y` high on consecutive valid cycles, and the count increments once per cycle.
- Reset assertion is asynchronous. Deassertion is taken synchronously to `clk` by the upstream reset synchroniser. The first bit is consumed on the first edge with `rst_n`=1.

## Structure
- Package `seq_det_pkg` contains:
  - Function `kmp_next(pattern, len, st, bit)`, returning the next matched length.
  - Function `kmp_fail(pattern, len)`, returning the border of the full pattern.
  - Both are used in constant context to build the next-state logic.
- Sub-module `sat_counter` (params `W`; ports `clk`, `rst_n`, `inc`, `clr`, `q`) provides `match_cnt`. It is reusable elsewhere in the design.
- The top level contains the state register, next-state mux and Moore decode.

## Test plan
- Default params, `ovl`=1, `din_vld`=1, stream 1011011 → `y` high after bits 4 and 7; `match_cnt`=2.
- Same stream, `ovl`=0 → `y` high after bit 4 only; `match_cnt`=1; final `st`=1.
- Valid gaps: bits 1,0,1,1 with `din_vld`=0 cycles between each → single match; `y` held high through trailing idle cycles until the next valid 0, then low; `match_cnt`=1.
- `CNT_W`=2, `ovl`=1, stream 1011011011011011 (5 matches) → `match_cnt` = 3, held there. `cnt_clr` pulsed on the cycle of a 6th match → `match_cnt`=0.
- Bits 1,0,1 received, then `rst_n` pulsed low mid-cycle → `y`=0, `match_cnt`=0 immediately. Next bit 1 → no match, `st`=1.
- `PAT_LEN`=3, `PATTERN`=3'b111, `ovl`=1, stream 11111 → `y` high on 3 consecutive cycles (after bits 3, 4, 5); `match_cnt`=3. With `ovl`=0 → one match; `match_cnt`=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and elaboration-time KMP helpers for the pattern detector
package seq_det_pkg;

    localparam int MAX_PAT_LEN = 16;

    // Overlap mode as seen on the ovl input when leaving the MATCH state
    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // Next matched length after taking bit b with st bits already matched (st < len).
    // Bit i of the received order is pattern[len-1-i]. Intended for constant context only.
    function automatic int kmp_next(input logic [MAX_PAT_LEN-1:0] pattern,
                                    input int len, input int st, input logic b);
        int   n;
        int   res;
        int   idx;
        logic ok;
        logic sb;
        res = 0;
        n   = st + 1;
        for (int k = n; k >= 1; k--) begin
            if (res == 0) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    idx = n - k + j;
                    sb  = (idx == st) ? b : pattern[len-1-idx];
                    if (pattern[len-1-j] != sb) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

    // Longest proper border of the full pattern (the KMP failure value of state len)
    function automatic int kmp_fail(input logic [MAX_PAT_LEN-1:0] pattern, input int len);
        int   res;
        logic ok;
        res = 0;
        for (int k = len - 1; k >= 1; k--) begin
            if (res == 0) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (pattern[len-1-j] != pattern[k-1-j]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] cnt_q;

    // Clear wins over increment; increment stops at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX_VAL)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_detect_moore.sv
// rtl/seq_detect_moore.sv - parametrised Moore serial pattern detector with match counter
module seq_detect_moore
    import seq_det_pkg::*;
#(
    parameter int               PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_vld,
    input  logic             ovl,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                     ST_W      = $clog2(PAT_LEN + 1);
    localparam int                     ST_NUM    = 2 ** ST_W;
    localparam logic [MAX_PAT_LEN-1:0] PAT_EXT   = MAX_PAT_LEN'(PATTERN);
    localparam int                     FAIL_ST   = kmp_fail(PAT_EXT, PAT_LEN);
    localparam logic [ST_W-1:0]        MATCH_ST  = ST_W'(PAT_LEN);
    localparam logic                   FIRST_BIT = PATTERN[PAT_LEN-1];

    logic [ST_W-1:0] st_q;
    logic [ST_W-1:0] st_d;
    logic            y_q;
    logic            cnt_inc;

    // Constant next-state values per state and input bit, folded at elaboration.
    // The MATCH entry holds the overlap transition (from the failure state);
    // unreachable encodings fall back to state 0.
    logic [ST_W-1:0] nxt0 [ST_NUM];
    logic [ST_W-1:0] nxt1 [ST_NUM];

    for (genvar s = 0; s < ST_NUM; s++) begin : g_tbl
        if (s <= PAT_LEN) begin : g_live
            localparam int FROM = (s == PAT_LEN) ? FAIL_ST : s;
            localparam int N0   = kmp_next(PAT_EXT, PAT_LEN, FROM, 1'b0);
            localparam int N1   = kmp_next(PAT_EXT, PAT_LEN, FROM, 1'b1);
            assign nxt0[s] = ST_W'(N0);
            assign nxt1[s] = ST_W'(N1);
        end else begin : g_pad
            assign nxt0[s] = '0;
            assign nxt1[s] = '0;
        end
    end

    // Next-state mux: hold on idle cycles, restart from MATCH in non-overlap mode
    always_comb begin
        st_d = st_q;
        if (din_vld) begin
            if ((st_q == MATCH_ST) && (ovl_mode_e'(ovl) == OVL_OFF)) begin
                st_d = (din == FIRST_BIT) ? ST_W'(1) : ST_W'(0);
            end else begin
                st_d = din ? nxt1[st_q] : nxt0[st_q];
            end
        end
    end

    // State register with registered Moore decode of MATCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
            y_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            y_q  <= (st_d == MATCH_ST);
        end
    end

    // Every valid bit landing in MATCH counts, including MATCH to MATCH
    assign cnt_inc = din_vld && (st_d == MATCH_ST);

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .q     (match_cnt)
    );

    assign y = y_q;

endmodule

// File: tb/tb_seq_detect_moore.sv
// tb/tb_seq_detect_moore.sv - scoreboard bench for seq_detect_moore over three parameter sets
module tb_seq_detect_moore;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       din;
    logic       din_vld;
    logic       ovl;
    logic       cnt_clr;
    logic       y_a, y_b, y_c;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [7:0] cnt_c;

    seq_detect_moore #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .ovl(ovl),
        .cnt_clr(cnt_clr), .y(y_a), .match_cnt(cnt_a));

    seq_detect_moore #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .ovl(ovl),
        .cnt_clr(cnt_clr), .y(y_b), .match_cnt(cnt_b));

    seq_detect_moore #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .ovl(ovl),
        .cnt_clr(cnt_clr), .y(y_c), .match_cnt(cnt_c));

    typedef struct packed {
        logic [2:0]      y;
        logic [2:0][7:0] cnt;
        logic [2:0][4:0] st;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    int          pl[3];
    int          cmax[3];
    int          nsince[3];
    int          cm[3];
    logic [15:0] pat[3];
    logic [31:0] sh[3];
    logic        ym[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Longest pattern prefix that ends the history received since the last restart
    function automatic int lps(input int i);
        int   best;
        int   lim;
        logic ok;
        best = 0;
        lim  = (nsince[i] < pl[i]) ? nsince[i] : pl[i];
        for (int k = 1; k <= lim; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (sh[i][k-1-j] != pat[i][pl[i]-1-j]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            nsince[i] = 0;
            sh[i]     = '0;
            ym[i]     = 1'b0;
            cm[i]     = 0;
        end
    endtask

    task automatic model_step(input logic b, input logic v, input logic o, input logic c);
        logic [31:0] mask;
        for (int i = 0; i < 3; i++) begin
            if (v) begin
                if (ym[i] && !o) begin
                    nsince[i] = 0;
                end
                sh[i]     = {sh[i][30:0], b};
                nsince[i] = nsince[i] + 1;
                mask      = (32'd1 << pl[i]) - 32'd1;
                ym[i]     = (nsince[i] >= pl[i]) && (((sh[i] ^ 32'(pat[i])) & mask) == 32'd0);
            end
            if (c) begin
                cm[i] = 0;
            end else if (v && ym[i] && (cm[i] < cmax[i])) begin
                cm[i] = cm[i] + 1;
            end
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e.y[i]   = ym[i];
            e.cnt[i] = 8'(cm[i]);
            e.st[i]  = 5'(lps(i));
        end
        return e;
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_y_a"},   32'(y_a),        32'(e.y[0]));
            check({tag, "_y_b"},   32'(y_b),        32'(e.y[1]));
            check({tag, "_y_c"},   32'(y_c),        32'(e.y[2]));
            check({tag, "_cnt_a"}, 32'(cnt_a),      32'(e.cnt[0]));
            check({tag, "_cnt_b"}, 32'(cnt_b),      32'(e.cnt[1]));
            check({tag, "_cnt_c"}, 32'(cnt_c),      32'(e.cnt[2]));
            check({tag, "_st_a"},  32'(dut_a.st_q), 32'(e.st[0]));
            check({tag, "_st_b"},  32'(dut_b.st_q), 32'(e.st[1]));
            check({tag, "_st_c"},  32'(dut_c.st_q), 32'(e.st[2]));
        end
    endtask

    task automatic step(input logic b, input logic v, input logic o, input logic c, input string tag);
        @(negedge clk);
        din     = b;
        din_vld = v;
        ovl     = o;
        cnt_clr = c;
        model_step(b, v, o, c);
        sb_q.push_back(snapshot());
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic send(input logic [31:0] bits, input int n, input logic o, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, o, 1'b0, tag);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_y_a"},   32'(y_a),        32'd0);
        check({tag, "_y_c"},   32'(y_c),        32'd0);
        check({tag, "_cnt_a"}, 32'(cnt_a),      32'd0);
        check({tag, "_cnt_b"}, 32'(cnt_b),      32'd0);
        check({tag, "_st_a"},  32'(dut_a.st_q), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        din_vld = 1'b0;
        cnt_clr = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset asserted between clock edges, checked before any edge arrives
    task automatic mid_reset(input string tag);
        #1;
        rst_n   = 1'b0;
        din_vld = 1'b0;
        cnt_clr = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic rb, rv, ro, rc;
        pl[0] = 4; pat[0] = 16'b1011; cmax[0] = 255;
        pl[1] = 4; pat[1] = 16'b1011; cmax[1] = 3;
        pl[2] = 3; pat[2] = 16'b111;  cmax[2] = 255;
        model_reset();
        rst_n   = 1'b0;
        din     = 1'b0;
        din_vld = 1'b0;
        ovl     = 1'b1;
        cnt_clr = 1'b0;

        do_reset("por");

        // Overlapping detection: matches after bits 4 and 7
        send(32'b1011011, 7, 1'b1, "ovl");
        check("ovl_cnt_final", 32'(cnt_a), 32'd2);
        check("ovl_y_final",   32'(y_a),   32'd1);

        // Non-overlapping: single match, restart leaves one bit matched
        do_reset("rst2");
        send(32'b1011011, 7, 1'b0, "novl");
        check("novl_cnt_final", 32'(cnt_a),      32'd1);
        check("novl_st_final",  32'(dut_a.st_q), 32'd1);
        check("novl_y_final",   32'(y_a),        32'd0);

        // Valid gaps between bits; y stretches over idle cycles
        do_reset("rst3");
        step(1'b1, 1'b1, 1'b1, 1'b0, "gap"); step(1'b0, 1'b0, 1'b1, 1'b0, "gap");
        step(1'b0, 1'b1, 1'b1, 1'b0, "gap"); step(1'b1, 1'b0, 1'b1, 1'b0, "gap");
        step(1'b1, 1'b1, 1'b1, 1'b0, "gap"); step(1'b0, 1'b0, 1'b1, 1'b0, "gap");
        step(1'b1, 1'b1, 1'b1, 1'b0, "gap");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, "gap_idle");
        end
        check("gap_y_held", 32'(y_a), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, "gap_end");
        check("gap_y_drop", 32'(y_a),   32'd0);
        check("gap_cnt",    32'(cnt_a), 32'd1);

        // Saturation of the 2-bit counter, then clear against a simultaneous match
        do_reset("rst4");
        send(32'b1011011011011011, 16, 1'b1, "sat");
        check("sat_cnt_b", 32'(cnt_b), 32'd3);
        check("sat_cnt_a", 32'(cnt_a), 32'd5);
        step(1'b0, 1'b1, 1'b1, 1'b0, "sat6");
        step(1'b1, 1'b1, 1'b1, 1'b0, "sat6");
        step(1'b1, 1'b1, 1'b1, 1'b1, "sat6_clr");
        check("clr_cnt_b", 32'(cnt_b), 32'd0);
        check("clr_cnt_a", 32'(cnt_a), 32'd0);
        check("clr_y_a",   32'(y_a),   32'd1);

        // Reset mid-pattern discards the partial match
        do_reset("rst5");
        send(32'b101, 3, 1'b1, "part");
        mid_reset("mid_rst");
        step(1'b1, 1'b1, 1'b1, 1'b0, "after_rst");
        check("after_rst_y",  32'(y_a),        32'd0);
        check("after_rst_st", 32'(dut_a.st_q), 32'd1);

        // All-ones pattern: self-overlapping run vs restart
        do_reset("rst6");
        send(32'b11111, 5, 1'b1, "ones_ovl");
        check("ones_ovl_cnt", 32'(cnt_c), 32'd3);
        do_reset("rst7");
        send(32'b11111, 5, 1'b0, "ones_novl");
        check("ones_novl_cnt", 32'(cnt_c), 32'd1);

        // Random mix of valid gaps, mode changes and clears
        do_reset("rst8");
        for (int n = 0; n < 400; n++) begin
            rb = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            ro = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 31) == 0);
            step(rb, rv, ro, rc, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
